// File: rtl/lc3b_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : lc3b_mem_arbiter
// Purpose  : Round-robin arbiter sharing the single-ported LC-3b memory
//            between the fetch and data requesters (IDLE -> ACCESS -> RESP).
// Revision : 1.0 - initial release
// ============================================================================
module lc3b_mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_ack,
    output logic [DATA_W-1:0] f_rdata,
    output logic              f_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [1:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              grant,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_t;

    localparam logic [7:0] c_timeout_last = 8'(TIMEOUT - 1);

    state_t            r_state,      w_state_nxt;
    logic              r_grant,      w_grant_nxt;
    logic              r_last_grant, w_last_grant_nxt;
    logic              r_we,         w_we_nxt;
    logic [1:0]        r_be,         w_be_nxt;
    logic [ADDR_W-1:0] r_addr,       w_addr_nxt;
    logic [DATA_W-1:0] r_wdata,      w_wdata_nxt;
    logic [7:0]        r_cnt,        w_cnt_nxt;
    logic              r_cs,         w_cs_nxt;
    logic              r_f_ack,      w_f_ack_nxt;
    logic [DATA_W-1:0] r_f_rdata,    w_f_rdata_nxt;
    logic              r_f_err,      w_f_err_nxt;
    logic              r_d_ack,      w_d_ack_nxt;
    logic [DATA_W-1:0] r_d_rdata,    w_d_rdata_nxt;
    logic              r_d_err,      w_d_err_nxt;

    logic              w_win_d;
    logic [1:0]        w_sel_be;
    logic [ADDR_W-1:0] w_sel_addr;
    logic              w_misaligned;

    // On a tie the requester that did not own the previous transfer wins.
    always_comb begin
        w_win_d      = d_req & (~f_req | ~r_last_grant);
        w_sel_be     = w_win_d ? d_be   : 2'b11;
        w_sel_addr   = w_win_d ? d_addr : f_addr;
        w_misaligned = (w_sel_be == 2'b00) ||
                       ((w_sel_be == 2'b11) && w_sel_addr[0]);
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_grant_nxt      = r_grant;
        w_last_grant_nxt = r_last_grant;
        w_we_nxt         = r_we;
        w_be_nxt         = r_be;
        w_addr_nxt       = r_addr;
        w_wdata_nxt      = r_wdata;
        w_cnt_nxt        = r_cnt;
        w_cs_nxt         = 1'b0;
        w_f_ack_nxt      = 1'b0;
        w_f_rdata_nxt    = '0;
        w_f_err_nxt      = 1'b0;
        w_d_ack_nxt      = 1'b0;
        w_d_rdata_nxt    = '0;
        w_d_err_nxt      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (f_req || d_req) begin
                    w_grant_nxt      = w_win_d;
                    w_last_grant_nxt = w_win_d;
                    w_we_nxt         = w_win_d ? d_we    : 1'b0;
                    w_be_nxt         = w_sel_be;
                    w_addr_nxt       = w_sel_addr;
                    w_wdata_nxt      = w_win_d ? d_wdata : '0;
                    if (w_misaligned) begin
                        // Rejected without ever touching memory.
                        w_state_nxt = ST_RESP;
                        w_f_ack_nxt = ~w_win_d;
                        w_f_err_nxt = ~w_win_d;
                        w_d_ack_nxt = w_win_d;
                        w_d_err_nxt = w_win_d;
                    end else begin
                        w_state_nxt = ST_ACCESS;
                        w_cs_nxt    = 1'b1;
                        w_cnt_nxt   = '0;
                    end
                end
            end

            ST_ACCESS: begin
                if (mem_ready) begin
                    w_state_nxt = ST_RESP;
                    w_f_ack_nxt = ~r_grant;
                    w_d_ack_nxt = r_grant;
                    if (!r_we) begin
                        w_f_rdata_nxt = r_grant ? '0 : mem_rdata;
                        w_d_rdata_nxt = r_grant ? mem_rdata : '0;
                    end
                end else if (r_cnt == c_timeout_last) begin
                    w_state_nxt = ST_RESP;
                    w_f_ack_nxt = ~r_grant;
                    w_f_err_nxt = ~r_grant;
                    w_d_ack_nxt = r_grant;
                    w_d_err_nxt = r_grant;
                end else begin
                    w_cs_nxt  = 1'b1;
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end

            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_we         <= 1'b0;
            r_be         <= 2'b00;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_cnt        <= '0;
            r_cs         <= 1'b0;
            r_f_ack      <= 1'b0;
            r_f_rdata    <= '0;
            r_f_err      <= 1'b0;
            r_d_ack      <= 1'b0;
            r_d_rdata    <= '0;
            r_d_err      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_we         <= w_we_nxt;
            r_be         <= w_be_nxt;
            r_addr       <= w_addr_nxt;
            r_wdata      <= w_wdata_nxt;
            r_cnt        <= w_cnt_nxt;
            r_cs         <= w_cs_nxt;
            r_f_ack      <= w_f_ack_nxt;
            r_f_rdata    <= w_f_rdata_nxt;
            r_f_err      <= w_f_err_nxt;
            r_d_ack      <= w_d_ack_nxt;
            r_d_rdata    <= w_d_rdata_nxt;
            r_d_err      <= w_d_err_nxt;
        end
    end

    assign state     = r_state;
    assign grant     = r_grant;
    assign mem_cs    = r_cs;
    assign mem_we    = r_we;
    assign mem_be    = r_be;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign f_ack     = r_f_ack;
    assign f_rdata   = r_f_rdata;
    assign f_err     = r_f_err;
    assign d_ack     = r_d_ack;
    assign d_rdata   = r_d_rdata;
    assign d_err     = r_d_err;

endmodule
`default_nettype wire

// File: tb/tb_lc3b_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_lc3b_mem_arbiter
// Purpose  : Self-checking bench for lc3b_mem_arbiter: transaction model
//            compared every cycle plus directed literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lc3b_mem_arbiter;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        f_req, f_ack, f_err;
    logic [15:0] f_addr, f_rdata;
    logic        d_req, d_we, d_ack, d_err;
    logic [1:0]  d_be;
    logic [15:0] d_addr, d_wdata, d_rdata;
    logic        mem_cs, mem_we, mem_ready;
    logic [1:0]  mem_be;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        grant;
    logic [1:0]  state;

    int errors = 0;
    int checks = 0;
    int delay  = 0;
    int cs_cnt = 0;

    lc3b_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata), .f_err(f_err),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .grant(grant), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory responder: ready after 'delay' wait cycles of a chip-select burst.
    always @(negedge clk) begin
        if (mem_cs === 1'b1) cs_cnt++;
        else                 cs_cnt = 0;
        mem_ready = (mem_cs === 1'b1) && (cs_cnt > delay);
    end

    // Transaction-level model: phase 0 idle, 1 memory access, 2 response.
    int          m_st, m_waited;
    logic        m_gnt, m_last, m_we, m_err;
    logic [1:0]  m_be;
    logic [15:0] m_addr, m_wdata, m_rd;

    task automatic model_step();
        if (!reset) begin
            m_st = 0; m_gnt = 0; m_last = 1; m_we = 0; m_be = 0;
            m_addr = 0; m_wdata = 0; m_waited = 0; m_err = 0; m_rd = 0;
        end else begin
            case (m_st)
                0: if (f_req || d_req) begin
                    m_gnt   = (f_req && d_req) ? !m_last : d_req;
                    m_last  = m_gnt;
                    m_we    = m_gnt ? d_we    : 1'b0;
                    m_be    = m_gnt ? d_be    : 2'b11;
                    m_addr  = m_gnt ? d_addr  : f_addr;
                    m_wdata = m_gnt ? d_wdata : 16'h0;
                    if (m_be == 2'b00 || (m_be == 2'b11 && m_addr[0])) begin
                        m_st = 2; m_err = 1; m_rd = 0;
                    end else begin
                        m_st = 1; m_waited = 0;
                    end
                end
                1: if (mem_ready) begin
                    m_st = 2; m_err = 0; m_rd = m_we ? 16'h0 : mem_rdata;
                end else begin
                    m_waited++;
                    if (m_waited == TIMEOUT) begin
                        m_st = 2; m_err = 1; m_rd = 0;
                    end
                end
                default: m_st = 0;
            endcase
        end
    endtask

    initial begin
        model_step();
        forever begin
            @(posedge clk or negedge reset);
            model_step();
        end
    end

    always @(negedge clk) begin
        chk("cyc_state",   {30'd0, state}, m_st);
        chk("cyc_grant",   {31'd0, grant}, {31'd0, m_gnt});
        chk("cyc_mem_cs",  {31'd0, mem_cs}, {31'd0, m_st == 1});
        chk("cyc_f_ack",   {31'd0, f_ack}, {31'd0, m_st == 2 && !m_gnt});
        chk("cyc_d_ack",   {31'd0, d_ack}, {31'd0, m_st == 2 && m_gnt});
        chk("cyc_f_rdata", {16'd0, f_rdata}, {16'd0, (m_st == 2 && !m_gnt) ? m_rd : 16'h0});
        chk("cyc_d_rdata", {16'd0, d_rdata}, {16'd0, (m_st == 2 && m_gnt) ? m_rd : 16'h0});
        chk("cyc_f_err",   {31'd0, f_err}, {31'd0, m_st == 2 && !m_gnt && m_err});
        chk("cyc_d_err",   {31'd0, d_err}, {31'd0, m_st == 2 && m_gnt && m_err});
        if (m_st == 1) begin
            chk("cyc_mem_we",   {31'd0, mem_we},   {31'd0, m_we});
            chk("cyc_mem_be",   {30'd0, mem_be},   {30'd0, m_be});
            chk("cyc_mem_addr", {16'd0, mem_addr}, {16'd0, m_addr});
            if (m_we) chk("cyc_mem_wdata", {16'd0, mem_wdata}, {16'd0, m_wdata});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input string name);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!(f_ack === 1'b1 || d_ack === 1'b1) && n < 60);
        chk(name, {31'd0, f_ack | d_ack}, 32'd1);
    endtask

    initial begin
        int n;
        reset = 0; f_req = 0; f_addr = 0; d_req = 0; d_we = 0; d_be = 0;
        d_addr = 0; d_wdata = 0; mem_rdata = 0; mem_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state",    {30'd0, state},    0);
        chk("rst_mem_cs",   {31'd0, mem_cs},   0);
        chk("rst_grant",    {31'd0, grant},    0);
        chk("rst_mem_addr", {16'd0, mem_addr}, 0);
        chk("rst_mem_be",   {30'd0, mem_be},   0);
        chk("rst_acks",     {30'd0, f_ack, d_ack}, 0);
        reset = 1;
        tick();

        // 1: single fetch, memory ready immediately
        delay = 0; mem_rdata = 16'h1A07; f_addr = 16'h3000; f_req = 1;
        tick();
        chk("t1_state_access", {30'd0, state}, 1);
        chk("t1_mem_cs",   {31'd0, mem_cs},   1);
        chk("t1_mem_addr", {16'd0, mem_addr}, 32'h3000);
        chk("t1_mem_we",   {31'd0, mem_we},   0);
        chk("t1_mem_be",   {30'd0, mem_be},   3);
        tick();
        chk("t1_state_resp", {30'd0, state}, 2);
        chk("t1_f_ack",   {31'd0, f_ack},   1);
        chk("t1_f_rdata", {16'd0, f_rdata}, 32'h1A07);
        chk("t1_f_err",   {31'd0, f_err},   0);
        chk("t1_cs_off",  {31'd0, mem_cs},  0);
        f_req = 0;
        tick();
        chk("t1_state_idle", {30'd0, state}, 0);
        chk("t1_ack_clear",  {31'd0, f_ack}, 0);

        // 2: byte store with three wait cycles
        delay = 3; d_req = 1; d_we = 1; d_be = 2'b01; d_addr = 16'h4001; d_wdata = 16'h00C3;
        tick();
        n = 0;
        while (mem_cs === 1'b1 && n < 100) begin
            chk("t2_mem_be",    {30'd0, mem_be},    1);
            chk("t2_mem_addr",  {16'd0, mem_addr},  32'h4001);
            chk("t2_mem_wdata", {16'd0, mem_wdata}, 32'h00C3);
            tick();
            n++;
        end
        chk("t2_cs_cycles", n, 4);
        chk("t2_d_ack",   {31'd0, d_ack},   1);
        chk("t2_d_err",   {31'd0, d_err},   0);
        chk("t2_d_rdata", {16'd0, d_rdata}, 0);
        d_req = 0; d_we = 0;
        tick();

        // 3: both requesters held high -> alternating grants
        delay = 0; mem_rdata = 16'h1234; f_addr = 16'h3004;
        d_be = 2'b11; d_addr = 16'h7000; f_req = 1; d_req = 1;
        for (int k = 0; k < 4; k++) begin
            wait_ack("t3_ack_seen");
            chk("t3_one_ack", {31'd0, f_ack ^ d_ack}, 1);
            chk($sformatf("t3_grant%0d", k), {31'd0, grant}, k % 2);
            if (k == 3) begin f_req = 0; d_req = 0; end
            tick();
        end

        // 4: misaligned accesses are rejected without memory access
        d_req = 1; d_we = 0; d_be = 2'b11; d_addr = 16'h5005;
        tick();
        chk("t4_state", {30'd0, state},  2);
        chk("t4_d_ack", {31'd0, d_ack},  1);
        chk("t4_d_err", {31'd0, d_err},  1);
        chk("t4_cs",    {31'd0, mem_cs}, 0);
        d_req = 0;
        tick();
        d_req = 1; d_we = 1; d_be = 2'b00; d_addr = 16'h4000;
        tick();
        chk("t4_be0_err", {31'd0, d_err}, 1);
        d_req = 0; d_we = 0;
        tick();
        f_req = 1; f_addr = 16'h3001;
        tick();
        chk("t4_f_err", {31'd0, f_err}, 1);
        f_req = 0;
        tick();

        // 5: timeout on a stuck memory, then a normal transfer
        delay = 1000; d_req = 1; d_we = 0; d_be = 2'b10; d_addr = 16'h6000;
        tick();
        n = 0;
        while (mem_cs === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("t5_cs_cycles", n, TIMEOUT);
        chk("t5_d_ack",   {31'd0, d_ack},   1);
        chk("t5_d_err",   {31'd0, d_err},   1);
        chk("t5_d_rdata", {16'd0, d_rdata}, 0);
        d_req = 0;
        tick();
        delay = 0; mem_rdata = 16'hBEEF; f_addr = 16'h3002; f_req = 1;
        tick();
        tick();
        chk("t5_next_ack",   {31'd0, f_ack},   1);
        chk("t5_next_rdata", {16'd0, f_rdata}, 32'hBEEF);
        chk("t5_next_err",   {31'd0, f_err},   0);
        f_req = 0;
        tick();

        // 6: asynchronous reset mid-access, then tie goes to fetch
        delay = 1000; d_req = 1; d_we = 0; d_be = 2'b11; d_addr = 16'h2000;
        tick();
        tick();
        chk("t6_in_access", {30'd0, state}, 1);
        #1 reset = 0;
        #1;
        chk("t6_cs_drop",    {31'd0, mem_cs}, 0);
        chk("t6_grant_drop", {31'd0, grant},  0);
        chk("t6_state_drop", {30'd0, state},  0);
        chk("t6_no_ack",     {31'd0, d_ack},  0);
        #4;
        reset = 1; delay = 0; mem_rdata = 16'h5A5A; f_addr = 16'h3006; f_req = 1;
        tick();
        chk("t6_tie_grant", {31'd0, grant}, 0);
        chk("t6_tie_state", {30'd0, state}, 1);
        wait_ack("t6_f_ack_seen");
        chk("t6_f_rdata", {16'd0, f_rdata}, 32'h5A5A);
        f_req = 0;
        wait_ack("t6_d_ack_seen");
        chk("t6_d_grant", {31'd0, grant},   1);
        chk("t6_d_rdata", {16'd0, d_rdata}, 32'h5A5A);
        d_req = 0;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/lc3b_mem_arbiter.md
Name: lc3b_mem_arbiter

Overview:
- Shares the single-ported LC-3b memory between the instruction-fetch requester and the data load/store requester of the control path.
- Sequences each transfer as IDLE -> ACCESS -> RESP.
- Supports variable-latency memory through a ready handshake, with a timeout.
- Rejects misaligned word accesses without touching memory.

Parameters:
- ADDR_W, 16, address width of both requesters and the memory port.
- DATA_W, 16, data width.
- TIMEOUT, 15, ACCESS cycles allowed without mem_ready before the access aborts with an error (1..255).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- f_req  in  1  fetch request; held high until f_ack.
- f_addr  in  ADDR_W  fetch address (word read).
- f_ack  out  1  one-cycle completion pulse for fetch.
- f_rdata  out  DATA_W  fetch read data, valid while f_ack=1.
- f_err  out  1  fetch error, valid while f_ack=1.
- d_req  in  1  data request; held high until d_ack.
- d_we  in  1  1=store, 0=load.
- d_be  in  2  byte enables: [1]=high byte, [0]=low byte.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_ack  out  1  one-cycle completion pulse for data.
- d_rdata  out  DATA_W  load data, valid while d_ack=1.
- d_err  out  1  data error, valid while d_ack=1.
- mem_cs  out  1  memory chip select.
- mem_we  out  1  memory write enable.
- mem_be  out  2  memory byte enables.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, sampled when mem_ready=1.
- mem_ready  in  1  memory completion, sampled only in ACCESS.
- grant  out  1  requester owning the current transfer: 0=fetch, 1=data.
- state  out  2  current state: 00=IDLE, 01=ACCESS, 10=RESP.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - All outputs 0, including mem_cs (drops immediately).
  - Internal last_grant=1, so fetch wins the first tie.
  - Wait counter=0.
  - An in-flight transfer is abandoned and no ack is issued.
- All outputs are registered. The mem_* outputs come from latched request registers, not directly from requester inputs.
- IDLE:
  - On a clock edge with f_req or d_req high, select a winner:
    - only one request high -> that requester wins;
    - both high -> the requester other than last_grant wins (round-robin).
  - Latch the winner's addr/we/be/wdata:
    - fetch latches we=0, be=11;
    - data latches the d_* signals.
  - Set grant and last_grant to the winner.
  - Misaligned check:
    - misaligned means be=11 with addr[0]=1, or be=00;
    - if misaligned, go to RESP with err=1 and never assert mem_cs;
    - otherwise go to ACCESS with counter=0.
- ACCESS:
  - mem_cs=1; mem_we/mem_be/mem_addr/mem_wdata are constant from the latched values.
  - mem_ready=1 at an edge -> capture mem_rdata into the winner's rdata register, err=0, go to RESP. mem_cs=0 in RESP.
  - Otherwise the counter increments. When counter==TIMEOUT-1 and mem_ready=0 -> go to RESP with err=1 and rdata=0.
- RESP:
  - The winner's ack=1 for exactly this one cycle.
  - rdata and err are valid in this cycle. Stores return rdata=0.
  - The loser's ack, rdata and err stay 0.
  - Next state is always IDLE.
  - ack, rdata and err return to 0 in IDLE.
- Latency:
  - Requests are sampled in IDLE only.
  - With mem_ready already high in the first ACCESS cycle, ack rises 2 edges after the sampling edge.
  - Each extra wait cycle adds 1.
  - A misaligned request acks 1 edge after sampling.
- Requesters must deassert req in the cycle after ack. A req still high in IDLE is treated as a new request.
- A request arriving during ACCESS/RESP waits; it is not lost while req stays high.
- Back-to-back with both requests held: grants alternate F, D, F, D.

Test Plan:
1. Reset, then f_req=1, f_addr=16'h3000, mem_ready tied 1, mem_rdata=16'h1A07 -> mem_cs high for 1 cycle with mem_addr=16'h3000, mem_we=0, mem_be=11; f_ack pulses 2 cycles after sampling with f_rdata=16'h1A07, f_err=0; state sequence 00, 01, 10, 00.
2. d_req with d_we=1, d_be=01, d_addr=16'h4001, d_wdata=16'h00C3, mem_ready delayed 3 cycles -> mem_cs held 4 cycles with stable mem_be=01, mem_addr=16'h4001, mem_wdata=16'h00C3; d_ack 1 cycle with d_err=0.
3. f_req and d_req asserted in the same cycle and held, requesters re-request immediately after each ack -> grant order is fetch, data, fetch, data; exactly one ack per RESP.
4. d_req load with d_be=11, d_addr=16'h5005 -> mem_cs never asserts; d_ack 1 edge after sampling with d_err=1.
5. d_req load with mem_ready stuck 0, TIMEOUT=15 -> mem_cs high exactly 15 cycles; d_ack with d_err=1, d_rdata=0; next request is served normally.
6. reset driven low for half a cycle during the 2nd ACCESS cycle -> mem_cs, grant and state drop to 0 asynchronously, no ack; after release, a tie is won by fetch.
